// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package fetch_stage_pkg;

  localparam logic [5:0]  OP_SPECIAL = 6'h00;
  localparam logic [5:0]  FN_SYSCALL = 6'h0C;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{ins: NOP_WORD, pc4: 32'h0, valid: 1'b0};

  function automatic logic is_syscall(input logic [31:0] word);
    return (word[31:26] == OP_SPECIAL) && (word[5:0] == FN_SYSCALL);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: fetch stage is master, memory is slave.
interface fetch_stage_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       data;

  modport master (output req, addr, input ready, data);
  modport slave  (input req, addr, output ready, data);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with flush (bubble), hold (stall) and load; a cycle that
// neither holds nor loads inserts a bubble. Reusable for later stages.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // flush beats hold beats load; idle cycles drain to a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= IF_ID_BUBBLE;
    else if (flush) q <= IF_ID_BUBBLE;
    else if (!hold) q <= load ? d : IF_ID_BUBBLE;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IM request, IF/ID register, syscall halt and
// the free-running cycle counter for the statistics display.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_ADDR_W = 10
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_stall,
  input  logic            in_redirect,
  input  logic [31:0]     in_target,
  fetch_stage_if.master   im,
  output logic [31:0]     out_is,
  output logic [31:0]     out_pc4,
  output logic            out_valid,
  output logic            out_halted,
  output logic [31:0]     out_cycles
);

  logic [31:0] pc;
  logic [0:0]  state;
  logic        accept;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign accept  = (state == ST_FETCH) && im.ready && !in_stall && !in_redirect;
  assign if_id_d = '{ins: im.data, pc4: pc + 32'd4, valid: 1'b1};

  // request drops immediately when reset is asserted, not at the next edge
  assign im.req  = !in_rst && (state == ST_FETCH) && !in_stall;
  assign im.addr = pc[IM_ADDR_W+1:2];

  // PC: redirect wins; otherwise advance only on an accepted fetch
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)           pc <= RESET_PC;
    else if (in_redirect) pc <= in_target & ~32'd3;
    else if (accept)      pc <= pc + 32'd4;
  end

  // FSM: halt after accepting a syscall; a redirect means it was wrong-path
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)                           state <= ST_FETCH;
    else if (in_redirect)                 state <= ST_FETCH;
    else if (accept && is_syscall(im.data)) state <= ST_HALT;
  end

  // cycle counter runs (and wraps) whenever fetch is not halted
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)                 out_cycles <= 32'h0;
    else if (state != ST_HALT)  out_cycles <= out_cycles + 32'd1;
  end

  fetch_stage_if_id_reg u_if_id (
    .clk   (in_clk),
    .rst   (in_rst),
    .flush (in_redirect),
    .hold  (in_stall),
    .load  (accept),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign out_is     = if_id_q.ins;
  assign out_pc4    = if_id_q.pc4;
  assign out_valid  = if_id_q.valid;
  assign out_halted = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for wrap and
// asynchronous reset, then randomized traffic against a reference model.
module tb_fetch_stage;

  logic        clk;
  logic        in_rst;
  logic        in_stall;
  logic        in_redirect;
  logic [31:0] in_target;
  logic [31:0] out_is;
  logic [31:0] out_pc4;
  logic        out_valid;
  logic        out_halted;
  logic [31:0] out_cycles;

  logic [31:0] mem [0:1023];

  int tests;
  int fails;

  fetch_stage_if #(.ADDR_W(10)) im_bus ();

  assign im_bus.data = mem[im_bus.addr];

  fetch_stage #(.RESET_PC(32'h0), .IM_ADDR_W(10)) dut (
    .in_clk      (clk),
    .in_rst      (in_rst),
    .in_stall    (in_stall),
    .in_redirect (in_redirect),
    .in_target   (in_target),
    .im          (im_bus),
    .out_is      (out_is),
    .out_pc4     (out_pc4),
    .out_valid   (out_valid),
    .out_halted  (out_halted),
    .out_cycles  (out_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: architectural view of the stage
  logic [31:0] m_pc;
  logic [31:0] m_is;
  logic [31:0] m_pc4;
  logic [31:0] m_cycles;
  bit          m_valid;
  bit          m_halted;

  task automatic model_reset();
    m_pc = 32'h0; m_is = 32'h0; m_pc4 = 32'h0; m_cycles = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
    logic [31:0] w;
    if (!m_halted) m_cycles = m_cycles + 32'd1;
    if (rd) begin
      m_pc = {tgt[31:2], 2'b00};
      m_valid = 1'b0; m_is = 32'h0; m_halted = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (!m_halted && rdy) begin
      w = mem[m_pc[11:2]];
      m_is = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (w[31:26] == 6'd0 && w[5:0] == 6'd12) m_halted = 1'b1;
    end else begin
      m_valid = 1'b0; m_is = 32'h0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, " is"}, out_is, m_is);
    if (m_valid) chk({tag, " pc4"}, out_pc4, m_pc4);
    chk({tag, " addr"}, {22'd0, im_bus.addr}, {22'd0, m_pc[11:2]});
    chk({tag, " halted"}, {31'd0, out_halted}, {31'd0, m_halted});
    chk({tag, " cycles"}, out_cycles, m_cycles);
    chk({tag, " req"}, {31'd0, im_bus.req}, {31'd0, (!m_halted && !in_stall)});
  endtask

  // drive inputs, take one edge, advance the model, settle past the edge
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
    in_stall = st; in_redirect = rd; in_target = tgt; im_bus.ready = rdy;
    @(posedge clk);
    model_edge(st, rd, tgt, rdy);
    #1;
  endtask

  typedef struct {
    bit          st;
    bit          rd;
    logic [31:0] tgt;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_is;
    logic [31:0] e_pc4;
    logic [9:0]  e_addr;
    bit          e_halt;
    logic [31:0] e_cyc;
    bit          e_req;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(bit st, bit rd, logic [31:0] tgt, bit rdy, bit ev,
                              logic [31:0] eis, logic [31:0] epc4, logic [9:0] ea,
                              bit eh, logic [31:0] ec, bit er);
    vec_t v;
    v.st = st; v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.e_valid = ev; v.e_is = eis;
    v.e_pc4 = epc4; v.e_addr = ea; v.e_halt = eh; v.e_cyc = ec; v.e_req = er;
    return v;
  endfunction

  initial begin
    tests = 0; fails = 0;
    in_rst = 1'b1; in_stall = 1'b0; in_redirect = 1'b0; in_target = 32'h0;
    im_bus.ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom | 32'h0400_0000;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[32'h11] = 32'h0000_000C;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid",  {31'd0, out_valid}, 32'd0);
    chk("rst is",     out_is, 32'd0);
    chk("rst pc4",    out_pc4, 32'd0);
    chk("rst halted", {31'd0, out_halted}, 32'd0);
    chk("rst cycles", out_cycles, 32'd0);
    chk("rst req",    {31'd0, im_bus.req}, 32'd0);
    chk("rst addr",   {22'd0, im_bus.addr}, 32'd0);
    in_rst = 1'b0;
    #1;
    chk("post-rst req", {31'd0, im_bus.req}, 32'd1);

    vecs[0]  = mk(0, 0, 32'h0,  1, 1, 32'h2008_0001, 32'd4,  10'h1,  0, 32'd1,  1);
    vecs[1]  = mk(0, 0, 32'h0,  1, 1, 32'h2009_0002, 32'd8,  10'h2,  0, 32'd2,  1);
    vecs[2]  = mk(0, 0, 32'h0,  1, 1, 32'h0109_5020, 32'd12, 10'h3,  0, 32'd3,  1);
    vecs[3]  = mk(0, 0, 32'h0,  0, 0, 32'h0,         32'd0,  10'h3,  0, 32'd4,  1);
    vecs[4]  = mk(0, 0, 32'h0,  0, 0, 32'h0,         32'd0,  10'h3,  0, 32'd5,  1);
    vecs[5]  = mk(0, 0, 32'h0,  1, 1, mem[3],        32'd16, 10'h4,  0, 32'd6,  1);
    vecs[6]  = mk(1, 0, 32'h0,  1, 1, mem[3],        32'd16, 10'h4,  0, 32'd7,  0);
    vecs[7]  = mk(1, 0, 32'h0,  1, 1, mem[3],        32'd16, 10'h4,  0, 32'd8,  0);
    vecs[8]  = mk(1, 0, 32'h0,  1, 1, mem[3],        32'd16, 10'h4,  0, 32'd9,  0);
    vecs[9]  = mk(0, 0, 32'h0,  1, 1, mem[4],        32'd20, 10'h5,  0, 32'd10, 1);
    vecs[10] = mk(1, 1, 32'h43, 1, 0, 32'h0,         32'd0,  10'h10, 0, 32'd11, 0);
    vecs[11] = mk(0, 0, 32'h0,  1, 1, mem[32'h10],   32'h44, 10'h11, 0, 32'd12, 1);
    vecs[12] = mk(0, 0, 32'h0,  1, 1, 32'h0000_000C, 32'h48, 10'h12, 1, 32'd13, 0);
    vecs[13] = mk(0, 0, 32'h0,  1, 0, 32'h0,         32'd0,  10'h12, 1, 32'd13, 0);
    vecs[14] = mk(0, 1, 32'h20, 0, 0, 32'h0,         32'd0,  10'h8,  0, 32'd13, 1);
    vecs[15] = mk(0, 0, 32'h0,  1, 1, mem[8],        32'h24, 10'h9,  0, 32'd14, 1);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].st, vecs[i].rd, vecs[i].tgt, vecs[i].rdy);
      chk($sformatf("v%0d valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d is", i), out_is, vecs[i].e_is);
      if (vecs[i].e_valid) chk($sformatf("v%0d pc4", i), out_pc4, vecs[i].e_pc4);
      chk($sformatf("v%0d addr", i), {22'd0, im_bus.addr}, {22'd0, vecs[i].e_addr});
      chk($sformatf("v%0d halted", i), {31'd0, out_halted}, {31'd0, vecs[i].e_halt});
      chk($sformatf("v%0d cycles", i), out_cycles, vecs[i].e_cyc);
      chk($sformatf("v%0d req", i), {31'd0, im_bus.req}, {31'd0, vecs[i].e_req});
    end

    // PC wraps modulo 2^32
    step(0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap addr", {22'd0, im_bus.addr}, 32'h3FF);
    step(0, 0, 32'h0, 1);
    chk("wrap is",   out_is, mem[1023]);
    chk("wrap pc4",  out_pc4, 32'h0);
    chk("wrap addr2", {22'd0, im_bus.addr}, 32'h0);
    check_model("wrap");

    // seed some syscalls and non-syscall SPECIAL words for the random phase
    for (int i = 0; i < 1024; i++) begin
      if (i % 29 == 7)  mem[i] = 32'h0000_000C;
      if (i % 29 == 11) mem[i] = 32'h0109_5020;
    end

    for (int n = 0; n < 400; n++) begin
      bit st, rd, rdy;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 65);
      tgt = $urandom;
      step(st, rd, tgt, rdy);
      check_model($sformatf("r%0d", n));

      if (n == 200) begin
        // asynchronous reset between edges while a request is waiting
        in_stall = 1'b0; in_redirect = 1'b0; im_bus.ready = 1'b0;
        #2;
        in_rst = 1'b1;
        #1;
        chk("arst valid",  {31'd0, out_valid}, 32'd0);
        chk("arst is",     out_is, 32'd0);
        chk("arst pc4",    out_pc4, 32'd0);
        chk("arst halted", {31'd0, out_halted}, 32'd0);
        chk("arst cycles", out_cycles, 32'd0);
        chk("arst req",    {31'd0, im_bus.req}, 32'd0);
        chk("arst addr",   {22'd0, im_bus.addr}, 32'd0);
        #2;
        in_rst = 1'b0;
        model_reset();
        step(0, 0, 32'h0, 1);
        chk("arst refetch", out_is, mem[0]);
        check_model("arst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
